regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between three writeback requesters: ALU, load unit and multi-cycle mul/div unit. Round-robin arbitration with a registered write port drives the register file's `Write`/`W_addr`/`Data` inputs. An integrated busy-register scoreboard lets the decode stage detect read-after-write hazards against writes still in flight.

---
 rtl/wb_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 80 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the register-file writeback arbiter.
package wb_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    // Requester slots on the shared write port
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: requesters drive Req/Req_addr/Req_data, the arbiter answers with Gnt.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = wb_pkg::NREQ,
    parameter int AW   = wb_pkg::AW,
    parameter int DW   = wb_pkg::DW
);
    logic [NREQ-1:0]    Req;
    logic [NREQ*AW-1:0] Req_addr;
    logic [NREQ*DW-1:0] Req_data;
    logic [NREQ-1:0]    Gnt;

    modport master (output Req, output Req_addr, output Req_data, input Gnt);
    modport slave  (input Req, input Req_addr, input Req_data, output Gnt);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NREQ-1:0] Req,
    output logic [NREQ-1:0] Gnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // Search from the priority pointer upward (mod NREQ); first active request wins.
    always_comb begin
        // NOTE: every output is given a default before the search so no path can infer a latch.
        Gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && Req[idx[PW-1:0]]) begin
                Gnt[idx[PW-1:0]] = 1'b1;
                ptr_d            = PW'((idx + 1) % NREQ);
                found            = 1'b1;
            end
        end
        // Nothing is accepted while reset is held
        if (Reset) begin
            Gnt   = '0;
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register
    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (Reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant, registered write port, busy scoreboard.
module regfile_wb_arbiter #(
    parameter int NREQ = wb_pkg::NREQ,
    parameter int AW   = wb_pkg::AW,
    parameter int DW   = wb_pkg::DW
) (
    input  logic                 Clock,
    input  logic                 Reset,
    regfile_wb_arbiter_if.slave  wb,
    output logic                 Write,
    output logic [AW-1:0]        W_addr,
    output logic [DW-1:0]        Data,
    input  logic                 Issue,
    input  logic [AW-1:0]        Issue_addr,
    input  logic [AW-1:0]        A_addr,
    input  logic [AW-1:0]        B_addr,
    output logic                 A_busy,
    output logic                 B_busy,
    output logic [(2**AW)-1:0]   Busy
);
    logic [NREQ-1:0]     gnt;
    logic                write_q, write_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DW-1:0]       data_q,  data_d;
    logic [(2**AW)-1:0]  busy_q,  busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .Clock (Clock),
        .Reset (Reset),
        .Req   (wb.Req),
        .Gnt   (gnt)
    );

    assign wb.Gnt = gnt;

    // Select the granted slice; r0 targets are consumed without a write pulse.
    always_comb begin
        write_d = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                waddr_d = wb.Req_addr[i*AW +: AW];
                data_d  = wb.Req_data[i*DW +: DW];
                write_d = (wb.Req_addr[i*AW +: AW] != '0);
            end
        end
    end

    // Scoreboard update: clear on commit, then set on issue so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (write_q) busy_d[waddr_q] = 1'b0;
        if (Issue && (Issue_addr != '0)) busy_d[Issue_addr] = 1'b1;
    end

    // Write-port and scoreboard registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            write_q <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            // NOTE: the busy bitmap is control state, not storage, so it must be cleared by reset.
            busy_q  <= '0;
        end else begin
            write_q <= write_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign Write  = write_q;
    assign W_addr = waddr_q;
    assign Data   = data_q;
    assign Busy   = busy_q;
    assign A_busy = busy_q[A_addr];
    assign B_busy = busy_q[B_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus reset corner sequence.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    typedef struct {
        logic [2:0]  req;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        issue;
        logic [4:0]  iaddr, aa, ba;
        logic [2:0]  gnt;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [31:0] busy;
        logic        ab, bb;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Write, A_busy, B_busy, Issue;
    logic [4:0]  W_addr, Issue_addr, A_addr, B_addr;
    logic [31:0] Data, Busy;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[17];

    regfile_wb_arbiter_if wbif ();

    regfile_wb_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .wb         (wbif.slave),
        .Write      (Write),
        .W_addr     (W_addr),
        .Data       (Data),
        .Issue      (Issue),
        .Issue_addr (Issue_addr),
        .A_addr     (A_addr),
        .B_addr     (B_addr),
        .A_busy     (A_busy),
        .B_busy     (B_busy),
        .Busy       (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic [2:0] req, input logic [4:0] a0, a1, a2,
        input logic [31:0] d0, d1, d2, input logic issue, input logic [4:0] iaddr, aa, ba,
        input logic [2:0] gnt, input logic wr, input logic [4:0] waddr,
        input logic [31:0] data, busy, input logic ab, bb);
        vec_t r;
        r.req = req; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.issue = issue; r.iaddr = iaddr; r.aa = aa; r.ba = ba;
        r.gnt = gnt; r.wr = wr; r.waddr = waddr; r.data = data;
        r.busy = busy; r.ab = ab; r.bb = bb;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        wbif.Req      = r.req;
        wbif.Req_addr = {r.a2, r.a1, r.a0};
        wbif.Req_data = {r.d2, r.d1, r.d0};
        Issue         = r.issue;
        Issue_addr    = r.iaddr;
        A_addr        = r.aa;
        B_addr        = r.ba;
    endtask

    task automatic check_outputs(input string tag, input vec_t r);
        check({tag, " Gnt"},    32'(wbif.Gnt), 32'(r.gnt));
        check({tag, " Write"},  32'(Write),    32'(r.wr));
        check({tag, " W_addr"}, 32'(W_addr),   32'(r.waddr));
        check({tag, " Data"},   Data,          r.data);
        check({tag, " Busy"},   Busy,          r.busy);
        check({tag, " A_busy"}, 32'(A_busy),   32'(r.ab));
        check({tag, " B_busy"}, 32'(B_busy),   32'(r.bb));
    endtask

    initial begin
        vec_t idle;
        vec_t cur;
        idle = v(3'b000, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b0, 5'd0, 5'd0, 5'd0,
                 3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Inputs applied #1 after an edge; expectations are sampled at the following negedge.
        //         req     a0    a1    a2    d0       d1            d2      iss  ia    aa    ba      gnt     wr  waddr data          busy          ab  bb
        vecs[0]  = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b000,1'b0,5'd0,32'h0,        32'h0,      1'b0,1'b0);
        vecs[1]  = v(3'b111,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b001,1'b0,5'd0,32'h0,        32'h0,      1'b0,1'b0);
        vecs[2]  = v(3'b111,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b010,1'b1,5'd1,32'h100,      32'h0,      1'b0,1'b0);
        vecs[3]  = v(3'b111,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b100,1'b1,5'd2,32'h200,      32'h0,      1'b0,1'b0);
        vecs[4]  = v(3'b111,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b001,1'b1,5'd3,32'h300,      32'h0,      1'b0,1'b0);
        vecs[5]  = v(3'b010,5'd1,5'd7,5'd3,32'h100,32'hDEADBEEF,32'h300,1'b0,5'd0,5'd0,5'd0, 3'b010,1'b1,5'd1,32'h100,      32'h0,      1'b0,1'b0);
        vecs[6]  = v(3'b000,5'd1,5'd7,5'd3,32'h100,32'hDEADBEEF,32'h300,1'b0,5'd0,5'd0,5'd0, 3'b000,1'b1,5'd7,32'hDEADBEEF, 32'h0,      1'b0,1'b0);
        vecs[7]  = v(3'b111,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b100,1'b0,5'd7,32'hDEADBEEF, 32'h0,      1'b0,1'b0);
        vecs[8]  = v(3'b001,5'd0,5'd2,5'd3,32'h55, 32'h200,     32'h300,1'b0,5'd0,5'd0,5'd0, 3'b001,1'b1,5'd3,32'h300,      32'h0,      1'b0,1'b0);
        vecs[9]  = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b1,5'd5,5'd5,5'd0, 3'b000,1'b0,5'd0,32'h55,       32'h0,      1'b0,1'b0);
        vecs[10] = v(3'b010,5'd1,5'd5,5'd3,32'h100,32'hA5A5,    32'h300,1'b0,5'd0,5'd5,5'd5, 3'b010,1'b0,5'd0,32'h55,       32'h20,     1'b1,1'b1);
        vecs[11] = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd5,5'd0, 3'b000,1'b1,5'd5,32'hA5A5,     32'h20,     1'b1,1'b0);
        vecs[12] = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b1,5'd9,5'd5,5'd0, 3'b000,1'b0,5'd5,32'hA5A5,     32'h0,      1'b0,1'b0);
        vecs[13] = v(3'b100,5'd1,5'd2,5'd9,32'h100,32'h200,     32'h99, 1'b0,5'd0,5'd9,5'd0, 3'b100,1'b0,5'd5,32'hA5A5,     32'h200,    1'b1,1'b0);
        vecs[14] = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b1,5'd9,5'd9,5'd9, 3'b000,1'b1,5'd9,32'h99,       32'h200,    1'b1,1'b1);
        vecs[15] = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b1,5'd0,5'd9,5'd0, 3'b000,1'b0,5'd9,32'h99,       32'h200,    1'b1,1'b0);
        vecs[16] = v(3'b000,5'd1,5'd2,5'd3,32'h100,32'h200,     32'h300,1'b0,5'd0,5'd0,5'd9, 3'b000,1'b0,5'd9,32'h99,       32'h200,    1'b0,1'b1);

        // Synchronous reset, then confirm the idle reset state
        Reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check_outputs("reset", idle);

        for (int i = 0; i < 17; i++) begin
            @(posedge Clock);
            #1 drive(vecs[i]);
            @(negedge Clock);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Mark r1..r31 busy one per cycle
        for (int a = 1; a < 32; a++) begin
            @(posedge Clock);
            cur = idle;
            cur.issue = 1'b1;
            cur.iaddr = 5'(a);
            #1 drive(cur);
        end

        // Full bitmap, then a grant to requester 0 in the cycle before reset
        @(posedge Clock);
        cur = idle;
        cur.req = 3'b111;
        #1 drive(cur);
        @(negedge Clock);
        check("full Busy", Busy, 32'hFFFF_FFFE);
        check("pre-reset Gnt", 32'(wbif.Gnt), 32'b001);

        // First reset cycle: no grant, but the earlier grant still pulses Write
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check("rst1 Gnt", 32'(wbif.Gnt), 32'b000);
        check("rst1 Write", 32'(Write), 32'd1);
        check("rst1 W_addr", 32'(W_addr), 32'd1);
        check("rst1 Data", Data, 32'h100);

        // Second reset cycle: everything cleared
        @(posedge Clock);
        @(negedge Clock);
        check("rst2 Gnt", 32'(wbif.Gnt), 32'b000);
        check("rst2 Write", 32'(Write), 32'd0);
        check("rst2 W_addr", 32'(W_addr), 32'd0);
        check("rst2 Data", Data, 32'h0);
        check("rst2 Busy", Busy, 32'h0);

        // Released: priority restarts at requester 0
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("post Gnt", 32'(wbif.Gnt), 32'b001);

        @(posedge Clock);
        #1 drive(idle);
        @(negedge Clock);
        check("post Write", 32'(Write), 32'd1);
        check("post W_addr", 32'(W_addr), 32'd1);
        check("post Data", Data, 32'h100);
        check("post Busy", Busy, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
